// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-ported, synchronous-read SRAM between the instruction-fetch
// port and the data load/store port of the core. Each access takes two cycles:
// an ISSUE cycle that drives the SRAM, then a RESP cycle that returns the read
// data and pulses the requester's valid. Data accesses win ties. A streak
// counter limits how many data grants in a row can pass a waiting fetch.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   inst_req, inst_addr         fetch request; held until inst_valid
//   inst_rdata, inst_valid      fetch response, one-cycle pulse
//   data_req, data_wen,         load/store request; held until data_valid
//   data_addr, data_wdata       (data_wen == 0000 means read)
//   data_rdata, data_valid      load data / store ack, one-cycle pulse
//   sram_en, sram_wen,          SRAM command, word-aligned byte address
//   sram_addr, sram_wdata
//   sram_rdata                  SRAM read data, valid the cycle after sram_en
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_valid,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_valid,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_I,
        ISSUE_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [STREAK_W-1:0] streak;
    logic [ADDR_W-1:0]   lat_addr;
    logic [3:0]          lat_wen;
    logic [31:0]         lat_wdata;

    logic                arb_point;
    logic                inst_elig;
    logic                data_elig;
    logic                grant_i;
    logic                grant_d;
    logic [ADDR_W-1:0]   word_addr;

    // A requester still holds req during its own valid cycle, so it must not
    // be granted again on that edge.
    assign arb_point = (state == IDLE) || (state == RESP_I) || (state == RESP_D);
    assign inst_elig = inst_req && (state != RESP_I);
    assign data_elig = data_req && (state != RESP_D);
    assign grant_d   = arb_point && data_elig && (!inst_elig || (streak < STREAK_MAX));
    assign grant_i   = arb_point && inst_elig && !grant_d;
    assign word_addr = lat_addr & ~ADDR_W'(3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        inst_valid = 1'b0;
        inst_rdata = '0;
        data_valid = 1'b0;
        data_rdata = '0;
        case (state)
            IDLE, RESP_I, RESP_D: begin
                if (grant_d) begin
                    state_next = ISSUE_D;
                end else if (grant_i) begin
                    state_next = ISSUE_I;
                end else begin
                    state_next = IDLE;
                end
                if (state == RESP_I) begin
                    inst_valid = 1'b1;
                    inst_rdata = sram_rdata;
                end
                if (state == RESP_D) begin
                    data_valid = 1'b1;
                    // A store returns zero data with its ack.
                    if (lat_wen == 4'b0000) begin
                        data_rdata = sram_rdata;
                    end
                end
            end
            ISSUE_I: begin
                state_next = RESP_I;
                sram_en    = 1'b1;
                sram_addr  = word_addr;
            end
            ISSUE_D: begin
                state_next = RESP_D;
                sram_en    = 1'b1;
                sram_addr  = word_addr;
                sram_wen   = lat_wen;
                sram_wdata = lat_wdata;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched request fields and the starvation counter. The latches hold
    // through RESP so the response can tell a store from a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak    <= '0;
            lat_addr  <= '0;
            lat_wen   <= 4'b0000;
            lat_wdata <= '0;
        end else begin
            if (grant_d) begin
                lat_addr  <= data_addr;
                lat_wen   <= data_wen;
                lat_wdata <= data_wdata;
            end else if (grant_i) begin
                lat_addr  <= inst_addr;
            end

            if (!inst_req || grant_i) begin
                streak <= '0;
            end else if (grant_d && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule
